// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side drain stage: word type, skid-buffer
// occupancy encoding and an occupancy helper used by the read-issue credit.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 32;

  typedef logic [FIFO_WIDTH_DEF-1:0] fifo_word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Words committed to the skid buffer: stored entries plus the one in flight.
  function automatic logic [2:0] occupancy(input skid_state_e cnt, input logic in_flight);
    return {1'b0, cnt} + {2'b00, in_flight};
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register buffer with push/pop and an occupancy count; the head
// entry is presented on head_data. Simultaneous push and pop keeps the count.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = FIFO_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [W-1:0] push_data,
  input  logic        pop,
  output skid_state_e count,
  output logic        valid,
  output logic [W-1:0] head_data
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  skid_state_e  count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != EMPTY);
    // A full buffer only accepts a word when the head leaves in the same cycle.
    do_push  = push && ((count_q != FULL) || do_pop);

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = skid_state_e'(count_q + 2'd1);
      2'b01:   count_d = skid_state_e'(count_q - 2'd1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= EMPTY;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count     = count_q;
  assign valid     = (count_q != EMPTY);
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_drain.sv
// FIFO read-side drain: issues rd_en on credit, captures data_out one cycle
// later into a skid buffer, and presents it as a valid/ready stream.
// Optional checker and words_out counter: define FIFO_RD_DRAIN_CHECK_EN.
module fifo_rd_drain
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_wr_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  if (SKID_DEPTH != 2) begin : g_bad_depth
    $error("fifo_rd_drain supports SKID_DEPTH = 2 only");
  end

  // Stream handshake: a word transfers in any cycle with m_valid && m_ready;
  // m_valid never drops and m_data never changes until that transfer happens.

  logic        in_flight_q, in_flight_d;
  logic        pop;
  logic [2:0]  occ_after_pop;
  skid_state_e count;

  assign pop = m_valid && m_ready;

  // Credit counts the word leaving this cycle, so a streaming consumer keeps
  // one read issued every cycle while the buffer can never overflow.
  always_comb begin
    occ_after_pop = occupancy(count, in_flight_q) - {2'b00, pop};
    fifo_rd_en    = en && !rst && !fifo_empty && !fifo_wr_en && (occ_after_pop < 3'd2);
    in_flight_d   = fifo_rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) in_flight_q <= 1'b0;
    else     in_flight_q <= in_flight_d;
  end

  fifo_skid_buf #(
    .W (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight_q),
    .push_data (fifo_data_out),
    .pop       (pop),
    .count     (count),
    .valid     (m_valid),
    .head_data (m_data)
  );

`ifdef FIFO_RD_DRAIN_CHECK_EN
  logic [31:0] words_out_q, words_out_d;

  always_comb words_out_d = words_out_q + {31'd0, pop};

  always_ff @(posedge clk) begin
    if (rst) words_out_q <= '0;
    else     words_out_q <= words_out_d;
  end

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst)
    !(fifo_rd_en && fifo_wr_en));
  a_rd_not_empty: assert property (@(posedge clk) disable iff (rst)
    fifo_rd_en |-> !fifo_empty);
  a_hold_stall: assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> ($stable(m_data) && m_valid));
  a_no_full_capture: assert property (@(posedge clk) disable iff (rst)
    !(in_flight_q && (count == FULL) && !pop));
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: behavioural FIFO model, per-cycle vector table for
// streaming and stall traffic, and directed sequences for the corner cases.
module tb_fifo_rd_drain;

  logic        clk;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic        fifo_wr_en;
  logic [31:0] fifo_data_out;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;

  logic        pre_push;
  logic        flush;
  logic [31:0] push_data;
  logic [31:0] mq[$];
  int          fifo_cnt;

  logic [31:0] exp_q[$];
  int          checks;
  int          errors;
  int          delivered;

  fifo_rd_drain #(.FIFO_WIDTH(32), .SKID_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: registered empty flag, data_out valid the cycle after rd_en
  always @(posedge clk) begin
    if (flush) mq.delete();
    if (fifo_rd_en) begin
      if (mq.size() > 0) fifo_data_out <= mq.pop_front();
      else               fifo_data_out <= 32'hDEAD_DEAD;
    end
    if (fifo_wr_en || pre_push) mq.push_back(push_data);
    fifo_cnt <= mq.size();
  end
  assign fifo_empty = (fifo_cnt == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard and boundary monitor
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      delivered++;
      if (exp_q.size() == 0) check("sb_unexpected_word", m_data, 32'hFFFF_FFFF);
      else                   check("sb_order", m_data, exp_q.pop_front());
    end
    if (!rst && fifo_rd_en) begin
      check("rd_wr_excl", {31'd0, fifo_wr_en}, 32'd0);
      check("rd_not_empty", {31'd0, fifo_empty}, 32'd0);
    end
  end

  // driver tasks
  task automatic cyc(input logic e, input logic r);
    @(posedge clk); #1;
    en = e; m_ready = r;
  endtask

  task automatic setup(input int n, input logic [31:0] base);
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b1; en = 1'b0; m_ready = 1'b0;
    fifo_wr_en = 1'b0; pre_push = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      pre_push = 1'b1; push_data = base + i;
      exp_q.push_back(base + i);
      @(posedge clk); #1;
    end
    pre_push = 1'b0;
    check("rd_en_in_reset", {31'd0, fifo_rd_en}, 32'd0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        setup;
    logic        en;
    logic        rdy;
    logic        rd;
    logic        mv;
    logic        md_care;
    logic [31:0] md;
  } vec_t;

  vec_t tv[20];
  int   rd_pulses;
  int   d0;

  initial begin
    checks = 0; errors = 0; delivered = 0;
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_wr_en = 1'b0;
    pre_push = 1'b0; flush = 1'b1; push_data = '0; fifo_data_out = '0; fifo_cnt = 0;

    // streaming (A0..A3, ready=1), then stalled consumer released
    tv[0]  = '{1, 1, 1, 1, 0, 1, 32'h00};
    tv[1]  = '{0, 1, 1, 1, 0, 1, 32'h00};
    tv[2]  = '{0, 1, 1, 1, 1, 1, 32'hA0};
    tv[3]  = '{0, 1, 1, 1, 1, 1, 32'hA1};
    tv[4]  = '{0, 1, 1, 0, 1, 1, 32'hA2};
    tv[5]  = '{0, 1, 1, 0, 1, 1, 32'hA3};
    tv[6]  = '{0, 1, 1, 0, 0, 0, 32'h00};
    tv[7]  = '{1, 1, 0, 1, 0, 1, 32'h00};
    tv[8]  = '{0, 1, 0, 1, 0, 1, 32'h00};
    tv[9]  = '{0, 1, 0, 0, 1, 1, 32'hA0};
    tv[10] = '{0, 1, 0, 0, 1, 1, 32'hA0};
    tv[11] = '{0, 1, 0, 0, 1, 1, 32'hA0};
    tv[12] = '{0, 1, 1, 1, 1, 1, 32'hA0};
    tv[13] = '{0, 1, 1, 1, 1, 1, 32'hA1};
    tv[14] = '{0, 1, 1, 0, 1, 1, 32'hA2};
    tv[15] = '{0, 1, 1, 0, 1, 1, 32'hA3};
    tv[16] = '{0, 1, 1, 0, 0, 0, 32'h00};
    tv[17] = '{0, 1, 1, 0, 0, 0, 32'h00};
    tv[18] = '{0, 0, 1, 0, 0, 0, 32'h00};
    tv[19] = '{0, 0, 0, 0, 0, 0, 32'h00};

    // reset state
    repeat (3) @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("reset_m_valid", {31'd0, m_valid}, 32'd0);
    check("reset_m_data", m_data, 32'd0);

    // vector table
    for (int i = 0; i < 20; i++) begin
      if (tv[i].setup) setup(4, 32'hA0);
      cyc(tv[i].en, tv[i].rdy);
      @(negedge clk);
      check($sformatf("vec%0d_rd_en", i), {31'd0, fifo_rd_en}, {31'd0, tv[i].rd});
      check($sformatf("vec%0d_m_valid", i), {31'd0, m_valid}, {31'd0, tv[i].mv});
      if (tv[i].md_care) check($sformatf("vec%0d_m_data", i), m_data, tv[i].md);
    end
    check("vec_drained", exp_q.size(), 0);

    // writes every other cycle while draining
    setup(8, 32'hC0);
    d0 = delivered;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      en = 1'b1; m_ready = 1'b1;
      fifo_wr_en = (k < 12) && (k % 2 == 0);
      push_data  = 32'hD0 + k;
      if (fifo_wr_en) exp_q.push_back(push_data);
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !fifo_wr_en) break;
    end
    fifo_wr_en = 1'b0;
    check("wr_mix_drained", exp_q.size(), 0);
    check("wr_mix_count", delivered - d0, 14);
`ifdef FIFO_RD_DRAIN_CHECK_EN
    check("words_out", dut.words_out_q, 32'd14);
`endif

    // reset while a word is in flight and one is buffered
    setup(4, 32'hA0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("rst_mid_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_mid_m_data", m_data, 32'd0);
    check("rst_mid_rd_en2", {31'd0, fifo_rd_en}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_late_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_late_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      @(posedge clk); #1;
    end

    // single word
    setup(1, 32'h5A);
    d0 = delivered;
    rd_pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1);
      @(negedge clk);
      if (fifo_rd_en) rd_pulses++;
    end
    check("single_rd_pulses", rd_pulses, 1);
    check("single_delivered", delivered - d0, 1);
    check("single_drained", exp_q.size(), 0);

    // en low holds off reads; raising en resumes immediately
    setup(2, 32'hE0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1);
      @(negedge clk);
      check("en_off_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      check("en_off_m_valid", {31'd0, m_valid}, 32'd0);
    end
    cyc(1'b1, 1'b1);
    @(negedge clk);
    check("en_on_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1);
    @(negedge clk);
    check("en_on_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
